// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings plus op legality for muldiv_unit.
// MULDIV_MADD_EN makes MADD/MSUB legal ops.
package muldiv_pkg;
  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MADD  = 4'b0110;
  localparam logic [3:0] OP_MSUB  = 4'b0111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;
  function automatic logic is_legal_op(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
    return op <= OP_MSUB;
`else
    return op <= OP_MTLO;
`endif
  endfunction
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-divide step on {rem,quo} against a divisor.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, i_dvs};
  assign o_rem  = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide into HI/LO.
// Define MULDIV_MADD_EN to build MADD/MSUB accumulation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_neg_q, r_neg_r, r_dz;
  logic             w_accept, w_is_mt, w_is_div, w_signed, w_dz, w_last;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem_n, w_quo_n;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod, w_sprod, w_divres, w_fix;
  assign o_busy   = r_state != ST_IDLE;
  assign w_accept = i_start && !o_busy && is_legal_op(i_op);
  assign w_is_mt  = i_op == OP_MTHI || i_op == OP_MTLO;
  assign w_is_div = i_op == OP_DIV || i_op == OP_DIVU;
  assign w_signed = i_op == OP_MULT || i_op == OP_DIV || i_op == OP_MADD || i_op == OP_MSUB;
  assign w_dz     = w_is_div && i_b == '0;
  assign w_abs_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_abs_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  // Multiply keeps the running high half in r_rem and the shifting multiplier in r_quo
  assign w_sum    = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : '0);
  assign w_prod   = {r_rem, r_quo};
  assign w_sprod  = r_neg_q ? -w_prod : w_prod;
  assign w_divres = {r_neg_r ? -r_rem : r_rem, r_neg_q ? -r_quo : r_quo};
`ifdef MULDIV_MADD_EN
  assign w_fix = r_op == OP_MADD ? {o_hi, o_lo} + w_sprod :
                 r_op == OP_MSUB ? {o_hi, o_lo} - w_sprod :
                 (r_op == OP_DIV || r_op == OP_DIVU) ? w_divres : w_sprod;
`else
  assign w_fix = (r_op == OP_DIV || r_op == OP_DIVU) ? w_divres : w_sprod;
`endif
  muldiv_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_dvs(r_dvs),
    .o_rem(w_rem_n),
    .o_quo(w_quo_n)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_is_mt) w_next = w_dz ? ST_FIX : w_is_div ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (w_last) w_next = ST_FIX;
      default: w_next = ST_IDLE;
    endcase
  end
  // Divide by zero loads rem=A, quo=all-ones with no sign fix so FIX writes them unchanged
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_op <= OP_MULT;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      o_done <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_hi <= '0;
      o_lo <= '0;
    end else begin
      o_done <= r_state == ST_FIX;
      o_div_by_zero <= r_state == ST_FIX && r_dz;
      if (w_accept && w_is_mt) begin
        if (i_op == OP_MTHI) o_hi <= i_a;
        else o_lo <= i_a;
      end else if (w_accept) begin
        r_op <= i_op;
        r_cnt <= '0;
        r_dz <= w_dz;
        r_dvs <= w_abs_b;
        r_rem <= w_dz ? i_a : '0;
        r_quo <= w_dz ? '1 : w_abs_a;
        r_neg_q <= !w_dz && w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_neg_r <= !w_dz && w_signed && i_a[WIDTH-1];
      end else if (r_state == ST_MUL) begin
        r_cnt <= r_cnt + 1'b1;
        {r_rem, r_quo} <= {w_sum, r_quo[WIDTH-1:1]};
      end else if (r_state == ST_DIV) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
      end else if (r_state == ST_FIX) begin
        {o_hi, o_lo} <= w_fix;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed HI/LO, busy length and flag values.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] op = 4'h0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, dbz;
  logic [W-1:0] hi, lo;
  int vec = 0, bad = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_op(op),
    .i_a(a),
    .i_b(b),
    .o_busy(busy),
    .o_done(done),
    .o_div_by_zero(dbz),
    .o_hi(hi),
    .o_lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 0; op = 4'hF; a = $urandom; b = $urandom;
    chk("done_low_after_accept", 64'(done), 64'd0);
  endtask
  task automatic finish_op(input string tag, input int cyc, input logic [W-1:0] eh,
                           input logic [W-1:0] el, input logic ez);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(cyc));
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " dbz"}, 64'(dbz), 64'(ez));
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1;
    launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
    finish_op("mult_neg3x7", 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    launch(OP_DIVU, 32'd100, 32'd7);
    finish_op("divu_100_7", 33, 32'd2, 32'd14, 1'b0);
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
    finish_op("div_neg7_2", 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    launch(OP_DIV, 32'h55, 32'd0);
    finish_op("div_by_zero", 1, 32'h55, 32'hFFFFFFFF, 1'b1);
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1; op = OP_MTLO; a = 32'd9;
    @(posedge clk);
    #1;
    start = 0; op = 4'hF;
    chk("mtlo_while_busy lo", 64'(lo), 64'hFFFFFFFF);
    finish_op("multu_max", 28, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    finish_op("div_min_neg1", 33, 32'h0, 32'h80000000, 1'b0);
    launch(OP_MULT, 32'h80000000, 32'h80000000);
    finish_op("mult_min_min", 33, 32'h40000000, 32'h0, 1'b0);
    launch(OP_DIV, 32'd7, 32'hFFFFFFFE);
    finish_op("div_7_neg2", 33, 32'd1, 32'hFFFFFFFD, 1'b0);
    launch(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi busy", 64'(busy), 64'd0);
    launch(4'b1000, 32'd3, 32'd3);
    chk("illegal busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("illegal hi", 64'(hi), 64'h1234);
    chk("illegal done", 64'(done), 64'd0);
    launch(OP_MULT, 32'd11, 32'd13);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst busy", 64'(busy), 64'd0);
    chk("async_rst done", 64'(done), 64'd0);
    chk("async_rst hi", 64'(hi), 64'd0);
    chk("async_rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1;
    launch(OP_MULT, 32'd6, 32'd7);
    finish_op("mult_6x7", 33, 32'd0, 32'd42, 1'b0);
    launch(OP_MTLO, 32'd5, 32'd0);
    chk("mtlo lo", 64'(lo), 64'd5);
    chk("mtlo busy", 64'(busy), 64'd0);
`ifdef MULDIV_MADD_EN
    launch(OP_MADD, 32'd2, 32'd3);
    finish_op("madd_2x3", 33, 32'd0, 32'd11, 1'b0);
    launch(OP_MSUB, 32'hFFFFFFFE, 32'd3);
    finish_op("msub_neg2x3", 33, 32'd0, 32'd17, 1'b0);
`else
    launch(OP_MADD, 32'd2, 32'd3);
    chk("madd_off busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("madd_off lo", 64'(lo), 64'd5);
    chk("madd_off done", 64'(done), 64'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
